dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the pipeline MEM stage. Accepts one load/store
//  request at a time over a valid/ready handshake and models a configurable
//  access latency. Returns a response (load data or store completion, plus
//  error flag) over a second valid/ready handshake.
//  The MEM stage holds the pipeline until the response is accepted.
// PARAMETERS
//  DEPTH_WORDS  2048  number of 32-bit words of storage (word-addressed internally)
//  LATENCY      2     wait cycles between request accept and access commit (0..15)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept a request this cycle
//  req_we     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data
//  req_be     in   4   byte enables for store (bit i -> byte i, little-endian)
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   consumer accepts response
//  rsp_rdata  out  32  load data; 0 for stores and errors
//  rsp_err    out  1   misaligned (addr[1:0]!=0) or word index >= DEPTH_WORDS
//  busy       out  1   1 in any state other than IDLE
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, req_ready=0, rsp_valid=0,
//    rsp_rdata=0, rsp_err=0, busy=0, wait counter=0. Storage is not cleared.
//    req_ready rises in the first cycle after reset deasserts.
//  - States: IDLE, WAIT, RESP.
//  - IDLE: req_ready=1. On req_valid&&req_ready, register we/addr/wdata/be.
//    Next state is WAIT with counter=LATENCY-1 if LATENCY>0, else RESP.
//  - WAIT: req_ready=0. Counter decrements each cycle.
//    At counter==0 the access commits on that clock edge and state goes to RESP.
//  - Commit:
//    - Error request: no write, rdata=0, err=1.
//    - Store: bytes with be=1 are written to mem[addr>>2], others unchanged; rdata=0.
//    - Load: rdata = mem[addr>>2]; be is ignored.
//  - Timing: rsp_valid is first seen LATENCY+1 cycles after the accept edge.
//  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready.
//    On rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
//  - No request is accepted in the cycle a response is consumed (req_ready=0 in RESP).
//    Minimum request-to-request spacing is LATENCY+2 cycles.
//  - Request inputs are ignored outside IDLE; there is no queueing.
//  - Reset asserted in WAIT drops the transaction with no write (commit is atomic).
//    Reset asserted in RESP drops the pending response.
//  - Word index = addr[$clog2(DEPTH_WORDS)+1:2]. Any address bit above that
//    range set to 1 is out of range -> err.
// TESTING
//  1. Store addr=0x10, wdata=0xDEADBEEF, be=4'hF, then load 0x10
//     -> rdata=0xDEADBEEF, err=0; rsp_valid exactly 3 cycles after accept (LATENCY=2).
//  2. Store 0x10 wdata=0x11223344 be=4'b0101 over 0xDEADBEEF, then load 0x10
//     -> 0xDE22BE44.
//  3. Load addr=0x12 (misaligned) and load addr=0x2000 (index 2048)
//     -> err=1, rdata=0. A following load of 0x10 shows memory unchanged.
//  4. Hold rsp_ready=0 for 5 cycles with the response pending
//     -> rsp_valid/rdata/err stable, req_ready=0 throughout.
//     Then rsp_ready=1 -> IDLE next cycle, and a new request is accepted the cycle after.
//  5. Store 0x20 accepted, then reset low for 1 cycle during WAIT
//     -> all outputs at reset values. A later load of 0x20 returns the prior contents.
//  6. LATENCY=0 build: accept load -> rsp_valid on the next cycle.
//     Back-to-back requests with rsp_ready=1 are accepted every 2 cycles.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and dmem_responder (slave).
// Request channel:  req_valid/req_ready handshake carrying we, byte address, wdata and byte enables.
// Response channel: rsp_valid/rsp_ready handshake carrying rdata and an error flag.
// busy: the responder is in any state other than idle.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline MEM stage.
// Accepts one load/store at a time, waits LATENCY cycles, commits the access and then holds
// the response until the consumer takes it.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset (storage is not cleared)
//   bus_io - slave side of dmem_responder_if (request channel, response channel, busy)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned LATENCY     = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus_io
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  // Any address bit above the word-index field marks the access out of range.
  localparam logic [31:0] HiMask = ~((32'd1 << (IdxW + 2)) - 32'd1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Access fields: taken straight from the bus when committing in idle (LATENCY == 0),
  // otherwise from the captured request.
  logic            acc_we;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;
  logic [IdxW-1:0] acc_idx;
  logic            idx_oob;
  logic            acc_err;
  logic            commit;
  logic            mem_we;
  logic [31:0]     wr_word;
  logic            accept;

  assign accept    = (state_q == StIdle) && ready_q && bus_io.req_valid;
  assign acc_we    = (state_q == StIdle) ? bus_io.req_we    : we_q;
  assign acc_addr  = (state_q == StIdle) ? bus_io.req_addr  : addr_q;
  assign acc_wdata = (state_q == StIdle) ? bus_io.req_wdata : wdata_q;
  assign acc_be    = (state_q == StIdle) ? bus_io.req_be    : be_q;
  assign acc_idx   = acc_addr[IdxW+1:2];

  if (DEPTH_WORDS == (32'd1 << IdxW)) begin : g_pow2
    assign idx_oob = 1'b0;
  end else begin : g_npow2
    assign idx_oob = ({1'b0, acc_idx} >= (IdxW + 1)'(DEPTH_WORDS));
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr & HiMask) != 32'd0) || idx_oob;

  always_comb begin
    wr_word = mem_q[acc_idx];
    for (int b = 0; b < 4; b++) begin
      if (acc_be[b]) wr_word[8*b +: 8] = acc_wdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = bus_io.req_we;
          addr_d  = bus_io.req_addr;
          wdata_d = bus_io.req_wdata;
          be_d    = bus_io.req_be;
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus_io.rsp_ready) begin
          state_d = StIdle;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? 32'd0 : mem_q[acc_idx];
    end
  end

  // Registered so req_ready stays low in the first cycle out of reset.
  assign ready_d = (state_d == StIdle);

  // Gated by reset level so a commit edge coinciding with reset never writes.
  assign mem_we = commit && acc_we && !acc_err && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[acc_idx] <= wr_word;
  end

  assign bus_io.req_ready = ready_q;
  assign bus_io.rsp_valid = (state_q == StResp);
  assign bus_io.rsp_rdata = rdata_q;
  assign bus_io.rsp_err   = err_q;
  assign bus_io.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned Lat = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(2048), .LATENCY(Lat)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  dmem_responder #(.DEPTH_WORDS(2048), .LATENCY(0)) u_dut0 (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus0.slave)
  );

  int n_vec;
  int n_bad;

  // Reference storage, word-indexed.
  logic [31:0] mdl [2048];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd, output logic err);
    int unsigned w;
    w   = addr / 4;
    err = (addr % 4 != 0) || (w >= 2048);
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mdl[w][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        rd = mdl[w];
      end
    end
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold, output logic [31:0] got_rd);
    int n;
    logic [31:0] exp_rd;
    logic        exp_err;
    got_rd = 32'd0;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom();
    bus.req_wdata = $urandom();
    bus.req_be    = 4'($urandom());
    model(we, addr, wdata, be, exp_rd, exp_err);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid !== 1'b1) chk("wait_busy", 32'(bus.busy), 32'd1);
    end while (bus.rsp_valid !== 1'b1 && n < 40);
    chk("rsp_latency", 32'(n), 32'(Lat + 1));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    got_rd = bus.rsp_rdata;
    // A stray request while the response is pending must be ignored.
    bus.req_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_err", 32'(bus.rsp_err), 32'(exp_err));
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_rdata", bus.rsp_rdata, 32'd0);
    chk("idle_err", 32'(bus.rsp_err), 32'd0);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({pfx, "_busy"}, 32'(bus.busy), 32'd0);
    chk({pfx, "_rdata"}, bus.rsp_rdata, 32'd0);
    chk({pfx, "_err"}, 32'(bus.rsp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int unsigned sel;
    int n;
    int acc;
    logic prev;

    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_be     = 4'd0;
    bus.rsp_ready  = 1'b0;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = 32'd0;
    bus0.req_wdata = 32'd0;
    bus0.req_be    = 4'd0;
    bus0.rsp_ready = 1'b0;

    #12;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("first_ready", 32'(bus.req_ready), 32'd1);

    // Known contents for the working window.
    for (int i = 0; i < 16; i++) run_txn(1'b1, 32'(i * 4), $urandom(), 4'hF, 0, rd);

    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    chk("t1_load", rd, 32'hDEADBEEF);

    run_txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd);
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd);
    chk("t2_merge", rd, 32'hDE22BE44);

    run_txn(1'b0, 32'h12, 32'h0, 4'h0, 0, rd);
    run_txn(1'b0, 32'h2000, 32'h0, 4'h0, 0, rd);
    run_txn(1'b1, 32'h2010, 32'hFFFFFFFF, 4'hF, 0, rd);
    run_txn(1'b1, 32'h80000010, 32'hFFFFFFFF, 4'hF, 0, rd);
    run_txn(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 0, rd);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    chk("t3_unchanged", rd, 32'hDE22BE44);

    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) << 2;
      if (sel == 7) a = a + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'h2000 + (32'($urandom_range(0, 2047)) << 2);
      else if (sel == 9) a = a | (32'd1 << $urandom_range(13, 31));
      run_txn(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom()),
              int'($urandom_range(0, 3)), rd);
    end

    // Reset during the wait window drops the store.
    run_txn(1'b1, 32'h20, 32'h01020304, 4'hF, 0, rd);
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hFFFFFFFF;
    bus.req_be    = 4'hF;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t5_in_wait", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_vals("t5_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_ready_back", 32'(bus.req_ready), 32'd1);
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    chk("t5_prior", rd, 32'h01020304);

    // Zero-latency instance.
    bus0.req_we    = 1'b1;
    bus0.req_addr  = 32'h40;
    bus0.req_wdata = 32'hCAFEF00D;
    bus0.req_be    = 4'hF;
    bus0.req_valid = 1'b1;
    n = 0;
    while (bus0.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("l0_ready", 32'(bus0.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    @(negedge clk);
    chk("l0_latency", 32'(bus0.rsp_valid), 32'd1);
    chk("l0_store_err", 32'(bus0.rsp_err), 32'd0);
    chk("l0_store_rdata", bus0.rsp_rdata, 32'd0);
    bus0.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.rsp_ready = 1'b0;
    @(negedge clk);
    chk("l0_idle_ready", 32'(bus0.req_ready), 32'd1);

    bus0.req_we    = 1'b0;
    bus0.req_valid = 1'b1;
    bus0.rsp_ready = 1'b1;
    acc  = 0;
    prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("l0_b2b_valid", 32'(bus0.rsp_valid), 32'(prev));
      if (prev) chk("l0_b2b_rdata", bus0.rsp_rdata, 32'hCAFEF00D);
      prev = bus0.req_ready;
      if (prev) acc++;
      @(negedge clk);
    end
    bus0.req_valid = 1'b0;
    bus0.rsp_ready = 1'b0;
    chk("l0_b2b_accepts", 32'(acc), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
